// File: rtl/resta_serial_nbits_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// Latency: none; wires only. The controller drives start/operands, the subtractor drives status/result.
// Backpressure: none; a start is taken only in IDLE and dropped otherwise. V exists only with SUB_OVF_EN.
interface resta_serial_nbits_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo;
`ifdef SUB_OVF_EN
    logic             V;
`endif

    modport master (
        output start, A, B, Bi,
`ifdef SUB_OVF_EN
        input  V,
`endif
        input  busy, done, D, Bo
    );

    modport slave (
        input  start, A, B, Bi,
`ifdef SUB_OVF_EN
        output V,
`endif
        output busy, done, D, Bo
    );
endinterface

// File: rtl/resta_serial_nbits.sv
// Bit-serial subtractor D = A - B - Bi, one bit per clock, LSB first. Optional V output under SUB_OVF_EN.
// Latency: the start edge is edge 0, and done pulses in the cycle after edge WIDTH. Throughput is 1 op per WIDTH+2 cycles.
// Backpressure: none; start is ignored while busy or in DONE. D/Bo/V hold until the next result.
module resta_serial_nbits #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    resta_serial_nbits_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bo;
`ifdef SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_v;
`endif

    // One full-subtractor cell fed by the operand LSBs and the registered borrow
    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_a        = r_a[0];
    assign w_b        = r_b[0];
    assign w_d        = w_a ^ w_b ^ r_borrow;
    assign w_bout     = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    assign w_last     = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_SHIFT;
            S_SHIFT: if (w_last)    w_next_state = S_DONE;
            S_DONE:                 w_next_state = S_IDLE;
            default:                w_next_state = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        bus.busy = (r_state == S_SHIFT);
        bus.done = (r_state == S_DONE);
    end

    assign bus.D  = r_d;
    assign bus.Bo = r_bo;
`ifdef SUB_OVF_EN
    assign bus.V  = r_v;
`endif

    // Datapath: latch operands on accept, shift one bit per SHIFT cycle, publish result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_d      <= '0;
            r_bo     <= 1'b0;
`ifdef SUB_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_v      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.A;
                        r_b      <= bus.B;
                        r_borrow <= bus.Bi;
                        r_res    <= '0;
                        r_cnt    <= '0;
`ifdef SUB_OVF_EN
                        r_a_msb  <= bus.A[WIDTH-1];
                        r_b_msb  <= bus.B[WIDTH-1];
`endif
                    end
                end
                S_SHIFT: begin
                    r_res    <= w_res_next;
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_d  <= w_res_next;
                        r_bo <= w_bout;
`ifdef SUB_OVF_EN
                        // The last computed bit is the result MSB
                        r_v  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_resta_serial_nbits.sv
// Self-checking bench for resta_serial_nbits against an integer-arithmetic reference.
// Latency: checks done timing relative to the start edge, and back-to-back spacing.
// Backpressure: checks that a start during SHIFT is dropped and that reset aborts an operation.
module tb_resta_serial_nbits;
    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [W-1:0] last_d;
    logic         last_bo;

    resta_serial_nbits_if #(.WIDTH(W)) ifc ();

    resta_serial_nbits #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and two's-complement views
    function automatic void model(input int a, input int b, input int bi,
                                  output logic [W-1:0] d, output logic bo, output logic v);
        int diff, sa, sb, sd;
        diff = a - b - bi;
        d    = W'(diff & ((1 << W) - 1));
        bo   = (a < b + bi);
        sa   = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb   = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        sd   = sa - sb - bi;
        v    = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    endfunction

    task automatic check_result(input string name, input int a, input int b, input int bi);
        logic [W-1:0] ed;
        logic         ebo, ev;
        model(a, b, bi, ed, ebo, ev);
        checks++;
        if (ifc.D !== ed || ifc.Bo !== ebo) begin
            failures++;
            $display("FAIL %s: A=%0d B=%0d Bi=%0d got D=%h Bo=%b expected D=%h Bo=%b",
                     name, a, b, bi, ifc.D, ifc.Bo, ed, ebo);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ifc.V !== ev) begin
            failures++;
            $display("FAIL %s_v: A=%0d B=%0d Bi=%0d got V=%b expected V=%b", name, a, b, bi, ifc.V, ev);
        end
`endif
        last_d  = ed;
        last_bo = ebo;
    endtask

    // Full operation: pulse start, check busy/hold, latency, result and single-cycle done
    task automatic run_op(input string name, input int a, input int b, input int bi);
        int k;
        @(negedge clk);
        ifc.start = 1'b1; ifc.A = W'(a); ifc.B = W'(b); ifc.Bi = bi[0];
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if (ifc.busy !== 1'b1 || ifc.D !== last_d || ifc.Bo !== last_bo) begin
            failures++;
            $display("FAIL %s_busy: busy=%b D=%h Bo=%b expected busy=1 D=%h Bo=%b",
                     name, ifc.busy, ifc.D, ifc.Bo, last_d, last_bo);
        end
        k = 0;
        while (ifc.done !== 1'b1 && k < W + 6) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != W) begin
            failures++;
            $display("FAIL %s_latency: done after %0d cycles expected %0d", name, k, W);
        end
        check_result(name, a, b, bi);
        @(negedge clk);
        checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse: done=%b busy=%b expected done=0 busy=0", name, ifc.done, ifc.busy);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.D !== '0 || ifc.Bo !== 1'b0) begin
            failures++;
            $display("FAIL %s: busy=%b done=%b D=%h Bo=%b expected all zero",
                     name, ifc.busy, ifc.done, ifc.D, ifc.Bo);
        end
`ifdef SUB_OVF_EN
        checks++;
        if (ifc.V !== 1'b0) begin
            failures++;
            $display("FAIL %s_v: V=%b expected 0", name, ifc.V);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        last_d = '0; last_bo = 1'b0;
    endtask

    task automatic test_directed();
        run_op("t1_9m3", 9, 3, 0);
        run_op("t2_3m9", 3, 9, 0);
        run_op("t3_7m8", 7, 8, 0);
        run_op("t4_0m0b1", 0, 0, 1);
        run_op("t4_5m5", 5, 5, 0);
        run_op("edge_8m0b1", 8, 0, 1);
        run_op("edge_15m15b1", 15, 15, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_op("random", int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, 1)));
    endtask

    // start pulsed two cycles into SHIFT must be dropped
    task automatic test_ignore_start();
        int k, extra;
        @(negedge clk);
        ifc.start = 1'b1; ifc.A = 4'd12; ifc.B = 4'd5; ifc.Bi = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (2) @(negedge clk);
        ifc.start = 1'b1; ifc.A = 4'd1; ifc.B = 4'd14; ifc.Bi = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        k = 3;
        while (ifc.done !== 1'b1 && k < W + 6) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != W) begin
            failures++;
            $display("FAIL ignore_latency: done after %0d cycles expected %0d", k, W);
        end
        check_result("ignore_result", 12, 5, 0);
        extra = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (ifc.done === 1'b1 || ifc.busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || ifc.D !== last_d) begin
            failures++;
            $display("FAIL ignore_second: active cycles=%0d D=%h expected 0 and D=%h", extra, ifc.D, last_d);
        end
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        ifc.start = 1'b1; ifc.A = 4'd6; ifc.B = 4'd2; ifc.Bi = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_midop");
        rst = 1'b0;
        last_d = '0; last_bo = 1'b0;
        run_op("after_reset", 10, 4, 1);
    endtask

    // start held high: one accept per return to IDLE, operands changed during each DONE cycle
    task automatic test_back_to_back();
        int oa[5], ob[5], obi[5];
        int cyc;
        for (int i = 0; i < 5; i++) begin
            oa[i]  = int'($urandom_range(0, (1 << W) - 1));
            ob[i]  = int'($urandom_range(0, (1 << W) - 1));
            obi[i] = int'($urandom_range(0, 1));
        end
        @(negedge clk);
        ifc.start = 1'b1; ifc.A = W'(oa[0]); ifc.B = W'(ob[0]); ifc.Bi = obi[0][0];
        for (int i = 0; i < 5; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (ifc.done !== 1'b1 && cyc < W + 8);
            checks++;
            if (cyc != ((i == 0) ? W + 1 : W + 2)) begin
                failures++;
                $display("FAIL b2b_spacing: op %0d took %0d cycles expected %0d",
                         i, cyc, (i == 0) ? W + 1 : W + 2);
            end
            check_result("b2b", oa[i], ob[i], obi[i]);
            if (i < 4) begin
                ifc.A = W'(oa[i + 1]); ifc.B = W'(ob[i + 1]); ifc.Bi = obi[i + 1][0];
            end else begin
                ifc.start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ifc.start = 1'b0; ifc.A = '0; ifc.B = '0; ifc.Bi = 1'b0;
        last_d = '0; last_bo = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_midop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
